usrt_tx_shifter: RTL and testbench
==================================

// Module: usrt_tx_shifter
// PURPOSE
//  Serializer stage directly downstream of txparity in the USRT transmit path.
//  - Accepts one framed character over a valid/ready handshake and shifts it out LSB-first on o_Tx.
//  - Drives a companion synchronous bit clock o_Sclk for the link partner.
//  - Reports busy/done status to the transmit controller.
// PARAMETERS
//  FRAME_W       11  frame width: [0]=start(0), [8:1]=data LSB-first, [9]=parity, [10]=stop(1)
//  CLKS_PER_BIT  4   i_Pclk cycles per serial bit; even, >=2
//  CNT_W         8   width of bit-period counter; must hold CLKS_PER_BIT-1
// PORTS
//  i_Pclk    in   1        system clock; all logic on rising edge
//  i_Rst     in   1        synchronous reset, active-high
//  i_Data    in   FRAME_W  frame from txparity (o_Data)
//  i_Parity  in   2        parity mode; 2'b00 = no parity bit, anything else = parity bit sent
//  i_Valid   in   1        frame present on i_Data/i_Parity
//  o_Ready   out  1        high only in IDLE; transfer occurs when i_Valid && o_Ready at a clock edge
//  o_Tx      out  1        serial data; idles high
//  o_Sclk    out  1        bit clock; low in idle, low first half / high second half of each bit
//  o_Busy    out  1        high from accept until last bit period ends
//  o_Done    out  1        one-cycle pulse when the last bit period ends
// BEHAVIOUR
//  Reset (synchronous, wins over all else, also mid-frame):
//   - State IDLE; o_Tx=1, o_Sclk=0, o_Busy=0, o_Done=0, o_Ready=1.
//   - Shift reg, bit index and period counter cleared; frame in flight is abandoned.
//  States: IDLE -> SHIFT -> DONE -> IDLE.
//  IDLE:
//   - o_Ready=1.
//   - On i_Valid: latch i_Data into shift reg and i_Parity==0 as skip_par.
//   - Bit count = 11, or 10 with parity skipped (bit 9 dropped; stop follows data).
//   - Clear counter; go to SHIFT. Inputs are ignored outside IDLE.
//  SHIFT:
//   - o_Tx = current bit, registered; start bit visible the cycle after accept.
//   - Period counter runs 0..CLKS_PER_BIT-1.
//   - o_Sclk=1 when counter >= CLKS_PER_BIT/2. Partner samples on rising o_Sclk, mid-bit.
//   - At counter wrap: advance to next bit, skipping index 9 when skip_par.
//   - After the stop bit's period: go to DONE.
//  DONE (one cycle):
//   - o_Done=1, o_Tx=1, o_Sclk=0, o_Busy=0, o_Ready=0; then IDLE.
//  Frame length: 11*CLKS_PER_BIT cycles (10*CLKS_PER_BIT with no parity).
//  Accept-to-accept minimum interval: frame length + 2 cycles.
//  i_Data is not checked; start/stop values are sent exactly as supplied.
// STRUCTURE
//  Shared package usrt_pkg:
//   - FRAME_W
//   - frame bit-index constants START_IDX=0, PAR_IDX=9, STOP_IDX=10
//   - parity-mode codes PAR_NONE=2'b00
//   - state encoding IDLE/SHIFT/DONE
//  One natural sub-module: usrt_bit_timer.
//   - Period counter, o_Sclk phase and a bit_end strobe.
//   - Reused later by the receive sampler.
//  FSM, shift register and bit index stay in this module.
// TESTING (CLKS_PER_BIT=4 unless stated)
//  1. Reset held 3 cycles -> o_Tx=1, o_Sclk=0, o_Ready=1, o_Busy=0, o_Done=0.
//  2. i_Data=11'h46A (data 0x35, par 0), i_Parity=2'b01, i_Valid 1 cycle
//     -> o_Tx = 0,1,0,1,0,1,1,0,0,0,1, each held 4 cycles (44 cycles).
//     -> o_Sclk toggles 2 low / 2 high per bit; o_Done pulses once; o_Ready back after.
//  3. Same frame, i_Parity=2'b00 -> 10 bits 0,1,0,1,0,1,1,0,0,1 (40 cycles); bit 9 not sent.
//  4. i_Valid held high continuously with frames 11'h46A then 11'h668
//     -> second accepted only in next IDLE; exactly 2 frames, gap 2 cycles.
//     -> i_Data changes while busy have no effect.
//  5. Reset asserted during bit 5 of a frame -> next cycle o_Tx=1, o_Sclk=0, o_Ready=1.
//     -> no o_Done; a new frame afterwards transmits correctly.
//  6. CLKS_PER_BIT=2, frame 11'h7FE -> 0 then ten 1s, 2 cycles each.
//     -> o_Sclk = 0,1 per bit; o_Busy high 22 cycles.

Source files
------------

// File: rtl/usrt_pkg.sv
// Shared USRT definitions: frame layout, parity-mode codes, transmit state encoding
// and the latched transmit request.
package usrt_pkg;

    localparam int FRAME_W   = 11;
    localparam int START_IDX = 0;
    localparam int PAR_IDX   = 9;
    localparam int STOP_IDX  = 10;
    localparam int IDX_W     = 4;

    localparam logic [1:0] PAR_NONE = 2'b00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } tx_state_e;

    typedef struct packed {
        logic [FRAME_W-1:0] frame;
        logic               skip_par;
    } tx_req_t;

endpackage

// File: rtl/usrt_bit_timer.sv
// Bit-period counter for the USRT link: produces the bit clock phase and a strobe
// on the last cycle of each bit period. Holds at zero while not running.
module usrt_bit_timer #(
    parameter int CLKS_PER_BIT = 4,
    parameter int CNT_W        = 8
) (
    input  logic i_Pclk,
    input  logic i_Rst,
    input  logic i_Run,
    output logic o_Sclk,
    output logic o_Bit_End
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge i_Pclk) begin
        if (i_Rst || !i_Run)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + CNT_W'(1);
    end

    // Low first half, high second half: the partner's rising-edge sample lands mid-bit.
    assign o_Sclk    = i_Run && (cnt >= HALF);
    assign o_Bit_End = i_Run && (cnt == LAST);

endmodule

// File: rtl/usrt_tx_shifter.sv
// USRT transmit serializer: accepts one framed character, sends it LSB-first with a
// companion bit clock, optionally dropping the parity bit.
module usrt_tx_shifter
    import usrt_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int CNT_W        = 8
) (
    input  logic               i_Pclk,
    input  logic               i_Rst,
    input  logic [FRAME_W-1:0] i_Data,
    input  logic [1:0]         i_Parity,
    input  logic               i_Valid,
    output logic               o_Ready,
    output logic               o_Tx,
    output logic               o_Sclk,
    output logic               o_Busy,
    output logic               o_Done
);

    tx_state_e        state, state_nxt;
    tx_req_t          req_q;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic             tx_q;
    logic             timer_sclk;
    logic             bit_end;
    logic             last_bit;

    usrt_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_bit_timer (
        .i_Pclk    (i_Pclk),
        .i_Rst     (i_Rst),
        .i_Run     (state == SHIFT),
        .o_Sclk    (timer_sclk),
        .o_Bit_End (bit_end)
    );

    assign last_bit = (idx == IDX_W'(STOP_IDX));

    // With parity skipped, the stop bit follows the last data bit directly.
    always_comb begin
        idx_nxt = idx + IDX_W'(1);
        if (req_q.skip_par && idx == IDX_W'(PAR_IDX - 1))
            idx_nxt = IDX_W'(STOP_IDX);
    end

    always_ff @(posedge i_Pclk) begin
        if (i_Rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_Valid) state_nxt = SHIFT;
            SHIFT:   if (bit_end && last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_Ready = 1'b0;
        o_Busy  = 1'b0;
        o_Done  = 1'b0;
        o_Sclk  = 1'b0;
        case (state)
            IDLE:    o_Ready = 1'b1;
            SHIFT: begin
                o_Busy = 1'b1;
                o_Sclk = timer_sclk;
            end
            DONE:    o_Done = 1'b1;
            default: o_Ready = 1'b0;
        endcase
    end

    // Frame is held whole and indexed, so the output bit is a clean flop.
    always_ff @(posedge i_Pclk) begin
        if (i_Rst) begin
            req_q <= '0;
            idx   <= '0;
            tx_q  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (i_Valid) begin
                        req_q.frame    <= i_Data;
                        req_q.skip_par <= (i_Parity == PAR_NONE);
                        idx            <= '0;
                        tx_q           <= i_Data[START_IDX];
                    end
                end
                SHIFT: begin
                    if (bit_end) begin
                        if (last_bit) begin
                            idx  <= '0;
                            tx_q <= 1'b1;
                        end else begin
                            idx  <= idx_nxt;
                            tx_q <= req_q.frame[idx_nxt];
                        end
                    end
                end
                default: tx_q <= 1'b1;
            endcase
        end
    end

    assign o_Tx = tx_q;

endmodule

// File: tb/tb_usrt_tx_shifter.sv
// Directed bench for usrt_tx_shifter: one instance at 4 clocks/bit, one at 2 clocks/bit.
module tb_usrt_tx_shifter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] data = '0;
    logic [1:0]  par = 2'b01;
    logic        vld4 = 1'b0;
    logic        vld2 = 1'b0;

    logic rdy4, tx4, sclk4, busy4, done4;
    logic rdy2, tx2, sclk2, busy2, done2;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    usrt_tx_shifter #(.CLKS_PER_BIT(4), .CNT_W(8)) dut4 (
        .i_Pclk (clk), .i_Rst (rst), .i_Data (data), .i_Parity (par), .i_Valid (vld4),
        .o_Ready (rdy4), .o_Tx (tx4), .o_Sclk (sclk4), .o_Busy (busy4), .o_Done (done4)
    );

    usrt_tx_shifter #(.CLKS_PER_BIT(2), .CNT_W(8)) dut2 (
        .i_Pclk (clk), .i_Rst (rst), .i_Data (data), .i_Parity (par), .i_Valid (vld2),
        .o_Ready (rdy2), .o_Tx (tx2), .o_Sclk (sclk2), .o_Busy (busy2), .o_Done (done2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {tx, sclk, ready, busy, done} of the selected instance
    function automatic logic [4:0] outs(input bit d2);
        return d2 ? {tx2, sclk2, rdy2, busy2, done2} : {tx4, sclk4, rdy4, busy4, done4};
    endfunction

    // Entered on the first cycle after accept; leaves on the first IDLE cycle after DONE.
    task automatic chk_frame(input string tag, input string bits, input int cpb, input bit d2);
        logic [4:0] o;
        for (int b = 0; b < bits.len(); b++) begin
            for (int c = 0; c < cpb; c++) begin
                o = outs(d2);
                chk({tag, "_tx"},   o[4], (bits[b] == 8'h31));
                chk({tag, "_sclk"}, o[3], (c >= cpb / 2));
                chk({tag, "_rdy"},  o[2], 1'b0);
                chk({tag, "_busy"}, o[1], 1'b1);
                chk({tag, "_done"}, o[0], 1'b0);
                tick();
            end
        end
        o = outs(d2);
        chk({tag, "_end"}, o, 5'b10001);
        tick();
        o = outs(d2);
        chk({tag, "_idle"}, o, 5'b10100);
    endtask

    initial begin
        int pulses;

        // 1: reset held 3 cycles
        repeat (3) tick();
        chk("rst4", outs(1'b0), 5'b10100);
        chk("rst2", outs(1'b1), 5'b10100);
        rst = 1'b0;
        tick();
        chk("post_rst", outs(1'b0), 5'b10100);

        // 2: frame with parity bit
        data = 11'h46A; par = 2'b01; vld4 = 1'b1;
        tick();
        vld4 = 1'b0;
        chk_frame("par", "01010110001", 4, 1'b0);

        // 3: same frame, parity bit dropped
        data = 11'h46A; par = 2'b00; vld4 = 1'b1;
        tick();
        vld4 = 1'b0;
        chk_frame("nopar", "0101011001", 4, 1'b0);

        // 4: valid held high, data changed while busy
        tick();
        data = 11'h46A; par = 2'b01; vld4 = 1'b1;
        tick();
        data = 11'h668;
        chk_frame("b2b1", "01010110001", 4, 1'b0);
        tick();
        chk_frame("b2b2", "00010110011", 4, 1'b0);
        vld4 = 1'b0;
        tick();
        chk("b2b_stop", outs(1'b0), 5'b10100);

        // 5: reset during bit 5 (bit value 0, sclk high)
        data = 11'h400; par = 2'b01; vld4 = 1'b1;
        tick();
        vld4 = 1'b0;
        repeat (5 * 4 + 2) tick();
        chk("mid_pre", outs(1'b0), 5'b01010);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst", outs(1'b0), 5'b10100);
        pulses = 0;
        repeat (60) begin
            tick();
            if (done4) pulses++;
        end
        chk("mid_nodone", pulses, 0);
        data = 11'h668; par = 2'b01; vld4 = 1'b1;
        tick();
        vld4 = 1'b0;
        chk_frame("after_rst", "00010110011", 4, 1'b0);

        // 6: 2 clocks per bit
        data = 11'h7FE; par = 2'b01; vld2 = 1'b1;
        tick();
        vld2 = 1'b0;
        chk_frame("cpb2", "01111111111", 2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
